// File: rtl/ifu_wide.sv
// Wide fetch unit: group-aligned I-cache lookup, miss handling, decoded instruction FIFO.
// Build with IFU_BTFN_PRED_EN to predict backward conditional branches taken.
module ifu_wide #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int IFIFO_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_WIDTH-1:0]              recovery_PC,
  input  logic                               recovery_PC_valid,
  output logic [ADDR_WIDTH-1:0]              icache_addr,
  input  logic                               icache_hit,
  input  logic [FETCH_WIDTH*INSTR_WIDTH-1:0] icache_data,
  output logic                               icache_fill,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic [ADDR_WIDTH-1:0]              mem_req_addr,
  input  logic                               mem_resp_valid,
  input  logic                               dispatch_ready,
  output logic                               instr_valid,
  output logic [INSTR_WIDTH+2*ADDR_WIDTH+1:0] instr_data
);
  localparam int EW  = INSTR_WIDTH + 2*ADDR_WIDTH + 2;
  localparam int PW  = $clog2(IFIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int SW  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int IB  = INSTR_WIDTH / 8;
  localparam int IBS = $clog2(IB);
  localparam logic [ADDR_WIDTH-1:0] GRP = ADDR_WIDTH'(FETCH_WIDTH * IB);

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] MISS_REQ  = 3'd1;
  localparam logic [2:0] MISS_WAIT = 3'd2;
  localparam logic [2:0] FILL      = 3'd3;
  localparam logic [2:0] DRAIN     = 3'd4;

  logic [2:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] mem_q [IFIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] grp_pc, seq_pc, nxt_pc;
  logic [SW-1:0] start;
  logic [CW-1:0] n_enq, free_n;
  logic [FETCH_WIDTH-1:0] slot_en;
  logic [EW-1:0] ent [FETCH_WIDTH];
  logic [PW-1:0] off [FETCH_WIDTH];
  logic fetch_go, deq, room, req, fill;

  logic [INSTR_WIDTH-1:0] ins;
  logic [ADDR_WIDTH-1:0] spc, tgt, jimm, bimm;
  logic is_jal, is_br, pred, stop;

  assign grp_pc      = pc_q & ~(GRP - ADDR_WIDTH'(1));
  assign seq_pc      = grp_pc + GRP;
  assign start       = SW'((pc_q >> IBS) & ADDR_WIDTH'(FETCH_WIDTH - 1));
  assign icache_addr = grp_pc;
  assign mem_req_addr = maddr_q;
  assign instr_valid = !rst && (cnt_q != '0);
  assign instr_data  = mem_q[rd_q];
  assign deq         = instr_valid && dispatch_ready;
  // A same-cycle dequeue frees a slot for this cycle's group.
  assign free_n = CW'(IFIFO_DEPTH) - cnt_q + CW'(deq);
  assign room   = free_n >= CW'(FETCH_WIDTH);
  assign fetch_go = (state_q == FETCH) && icache_hit && room &&
                    !recovery_PC_valid;

  always_comb begin
    stop = 1'b0;
    n_enq = '0;
    nxt_pc = seq_pc;
    slot_en = '0;
    ins = '0;
    spc = '0;
    tgt = '0;
    jimm = '0;
    bimm = '0;
    is_jal = 1'b0;
    is_br = 1'b0;
    pred = 1'b0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      ins = icache_data[k*INSTR_WIDTH +: INSTR_WIDTH];
      spc = grp_pc + ADDR_WIDTH'(k * IB);
      jimm = {{(ADDR_WIDTH-21){ins[31]}}, ins[31], ins[19:12],
              ins[20], ins[30:21], 1'b0};
      bimm = {{(ADDR_WIDTH-13){ins[31]}}, ins[31], ins[7],
              ins[30:25], ins[11:8], 1'b0};
      is_jal = ins[6:0] == 7'b1101111;
      is_br  = ins[6:0] == 7'b1100011;
`ifdef IFU_BTFN_PRED_EN
      pred = is_jal || (is_br && ins[31]);
`else
      pred = is_jal;
`endif
      tgt = is_jal ? spc + jimm : (is_br ? spc + bimm : '0);
      ent[k] = {ins, spc, is_br, pred, tgt};
      off[k] = PW'(n_enq);
      if (fetch_go && (k >= int'(start)) && !stop) begin
        slot_en[k] = 1'b1;
        n_enq = n_enq + CW'(1);
        if (pred) begin
          stop = 1'b1;
          nxt_pc = tgt;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    maddr_d = maddr_q;
    req = 1'b0;
    fill = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (!icache_hit) begin
          maddr_d = grp_pc;
          state_d = MISS_REQ;
        end else if (fetch_go) begin
          pc_d = nxt_pc;
        end
      end
      MISS_REQ: begin
        req = 1'b1;
        if (mem_req_ready) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (mem_resp_valid) begin
          fill = 1'b1;
          state_d = FILL;
        end
      end
      FILL: state_d = FETCH;
      DRAIN: begin
        if (mem_resp_valid) begin
          fill = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    // pc_q doubles as the saved redirect target while draining.
    if (recovery_PC_valid) begin
      pc_d = recovery_PC;
      unique case (state_q)
        MISS_REQ:  state_d = mem_req_ready ? DRAIN : FETCH;
        MISS_WAIT: state_d = mem_resp_valid ? FETCH : DRAIN;
        DRAIN:     state_d = mem_resp_valid ? FETCH : DRAIN;
        default:   state_d = FETCH;
      endcase
    end
  end

  assign mem_req_valid = req && !rst;
  assign icache_fill   = fill && !rst;

  always_comb begin
    wr_d  = wr_q + PW'(n_enq);
    rd_d  = rd_q + PW'(deq);
    cnt_d = cnt_q + n_enq - CW'(deq);
    if (recovery_PC_valid) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      maddr_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      maddr_q <= maddr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++)
      if (slot_en[k]) mem_q[wr_q + off[k]] <= ent[k];
  end
endmodule

// File: doc/ifu_wide.md
IFU_WIDE -- requirements
Module: ifu_wide

Interface
REQ-001 Parameter ADDR_WIDTH, 32, PC/address width.
REQ-002 Parameter INSTR_WIDTH, 32, instruction width.
REQ-003 Parameter FETCH_WIDTH, 2, instructions per fetch group; power of 2, 1..8.
REQ-004 Parameter IFIFO_DEPTH, 8, instruction FIFO entries; power of 2, at least FETCH_WIDTH.
REQ-005 Parameter RESET_PC, 0, PC loaded at reset.
REQ-006 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port recovery_PC, input, ADDR_WIDTH, redirect target from backend.
REQ-009 Port recovery_PC_valid, input, 1, redirect strobe.
REQ-010 Port icache_addr, output, ADDR_WIDTH, group-aligned lookup address, combinational from PC.
REQ-011 Port icache_hit, input, 1, same-cycle hit for icache_addr.
REQ-012 Port icache_data, input, FETCH_WIDTH*INSTR_WIDTH, aligned group; slot k at bits [k*INSTR_WIDTH +: INSTR_WIDTH].
REQ-013 Port icache_fill, output, 1, one-cycle write strobe to the I-cache.
REQ-014 Port mem_req_valid / mem_req_ready / mem_req_addr, output/input/output, 1/1/ADDR_WIDTH, miss request handshake.
REQ-015 Port mem_resp_valid, input, 1, fill data present at the I-cache write port.
REQ-016 Port dispatch_ready, input, 1, rename accepts one entry.
REQ-017 Port instr_valid, output, 1, FIFO head valid.
REQ-018 Port instr_data, output, INSTR_WIDTH+2*ADDR_WIDTH+2, {instr, PC, is_cond_branch, br_prediction, target_PC}.

Function
REQ-019 FSM states are FETCH, MISS_REQ, MISS_WAIT, FILL, DRAIN; reset state is FETCH.
REQ-020 In FETCH on hit with at least FETCH_WIDTH free FIFO slots, slots from PC slot index up to FETCH_WIDTH-1 SHALL enqueue in one cycle, stopping after the first predicted-taken slot.
REQ-021 In FETCH on hit with fewer than FETCH_WIDTH free slots, the FSM SHALL enqueue nothing and hold PC.
REQ-022 A JAL (opcode 1101111) SHALL always be predicted taken with target slot PC + J-immediate.
REQ-023 A B-type (opcode 1100011) SHALL set is_cond_branch=1 with target slot PC + B-immediate; its prediction SHALL follow REQ-040.
REQ-024 Next PC with a predicted-taken slot SHALL be that slot's target, otherwise the aligned group address + FETCH_WIDTH*INSTR_WIDTH/8, with modulo 2^ADDR_WIDTH wrap.
REQ-025 On miss in FETCH: mem_req_addr <= aligned PC and go to MISS_REQ.
REQ-026 MISS_REQ: mem_req_valid=1; on mem_req_ready go to MISS_WAIT.
REQ-027 MISS_WAIT: on mem_resp_valid, icache_fill=1 that cycle, then go to FILL.
REQ-028 FILL lasts one cycle, then returns to FETCH, which retries the same PC.
REQ-029 recovery_PC_valid SHALL take priority over all events: PC <= recovery_PC and the FIFO is flushed, including a same-cycle enqueue or dequeue.
REQ-030 Recovery in FETCH, FILL, or MISS_REQ without mem_req_ready SHALL go to FETCH.
REQ-031 Recovery in MISS_WAIT, or in MISS_REQ with mem_req_ready, SHALL go to DRAIN.
REQ-032 DRAIN SHALL wait for mem_resp_valid, assert icache_fill, then go to FETCH at the saved redirect PC.
REQ-033 A recovery received in DRAIN SHALL overwrite the saved PC.
REQ-034 Dequeue SHALL occur when instr_valid and dispatch_ready are both 1.
REQ-035 Simultaneous enqueue and dequeue SHALL be legal at full occupancy minus the dequeue.
REQ-036 Pointers SHALL wrap modulo IFIFO_DEPTH; the count SHALL be log2(IFIFO_DEPTH)+1 bits wide.
REQ-037 instr_data SHALL be registered FIFO head data; enqueue-to-instr_valid latency is one cycle.

Reset
REQ-038 When rst=1, PC SHALL be set to RESET_PC, the FIFO emptied, and the state set to FETCH.
REQ-039 During and after rst: instr_valid=0, mem_req_valid=0, icache_fill=0. A reset mid-miss SHALL abandon the request, and later mem_resp_valid SHALL be ignored.

Configuration
REQ-040 Macro IFU_BTFN_PRED_EN: when defined, a B-type with negative immediate is predicted taken and a non-negative one not-taken; when undefined, all B-types are predicted not-taken (br_prediction=0).

Verification
REQ-041 FETCH_WIDTH=2, PC=0x100, hit, two ALU ops -> two entries with PCs 0x100/0x104; next PC 0x108.
REQ-042 PC=0x104, hit -> one entry (slot 1 only); next PC 0x108.
REQ-043 Slot 0 JAL imm=+0x40 at 0x200 -> one entry, target 0x240, next PC 0x240; slot 1 not enqueued.
REQ-044 Miss at 0x300, mem_req_ready after 2 cycles, mem_resp_valid after 5 more -> icache_fill for one cycle, FILL, then hit enqueues 0x300/0x304.
REQ-045 Recovery to 0x500 in MISS_WAIT -> FIFO empty next cycle, DRAIN until mem_resp_valid, then icache_addr=0x500.
REQ-046 B-type imm=-8 at 0x400: with IFU_BTFN_PRED_EN, br_prediction=1 and next PC 0x3F8; without it, br_prediction=0 and next PC 0x408.
